detector_campos: RTL and testbench
==================================

DETECTOR_CAMPOS -- requirements
Module: detector_campos

Interface
REQ-001 Parameter N_CAMPOS, default 7, SHALL set the number of numeric fields entered per sample.
REQ-002 Parameter N_DIGITOS, default 3, SHALL set the maximum decimal digits per field; W_VAL = ceil(log2(10^N_DIGITOS)) (10 at default).
REQ-003 Parameter W_PESO, default 8, SHALL set the unsigned weight width; W_PONT = W_VAL + W_PESO + ceil(log2(N_CAMPOS)) (21 at default).
REQ-004 Port list (name, direction, width, meaning):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- teclas  in  10  digit keys 0-9; bit d = key d; level, already debounced and synchronous.
- tecla_proximo  in  1  "next field" key, level.
- tecla_limpar  in  1  synchronous clear key, level.
- pesos  in  N_CAMPOS*W_PESO  unsigned weights; field i uses bits [i*W_PESO +: W_PESO].
- limiar  in  W_PONT  unsigned decision threshold.
- estado  out  2  0=ENTRADA, 1=CALCULO, 2=RESULTADO.
- campo  out  ceil(log2(N_CAMPOS))  index of field being entered.
- digitos_bcd  out  4*N_DIGITOS  BCD of current field, least significant digit in [3:0].
- n_digitos  out  ceil(log2(N_DIGITOS+1))  digits entered in current field.
- pontuacao  out  W_PONT  weighted sum.
- resultado  out  1  1 when pontuacao >= limiar.
- pronto  out  1  high while in RESULTADO.

Function
REQ-005 Every key input SHALL be edge-detected against its previous-cycle sample; a key event occurs only on the cycle a key is sampled 1 after being sampled 0; holding a key SHALL generate exactly one event.
REQ-006 Event priority SHALL be tecla_limpar > tecla_proximo > digit; lower-priority events in the same cycle are discarded.
REQ-007 A digit event with more than one new teclas bit rising in the same cycle SHALL be ignored.
REQ-008 All outputs SHALL be registered; the effect of an event SHALL be visible on the cycle after the edge at which it is detected.
REQ-009 ENTRADA, digit d, n_digitos < N_DIGITOS: digitos_bcd shifts left one digit with d inserted at [3:0], field value becomes value*10 + d, n_digitos increments.
REQ-010 ENTRADA, digit event with n_digitos = N_DIGITOS SHALL be ignored (no wrap, no overflow).
REQ-011 ENTRADA, tecla_proximo with campo < N_CAMPOS-1: store field value, campo increments, digitos_bcd and n_digitos clear; zero digits entered stores value 0.
REQ-012 ENTRADA, tecla_proximo with campo = N_CAMPOS-1: store value, enter CALCULO, clear accumulator and iteration index.
REQ-013 CALCULO SHALL perform one multiply-accumulate per cycle, acc += valor[i] * pesos[i], for i = 0..N_CAMPOS-1, in exactly N_CAMPOS cycles, then enter RESULTADO.
REQ-014 On entering RESULTADO: pontuacao = acc, resultado = (acc >= limiar), pronto = 1; limiar is sampled on the final CALCULO cycle.
REQ-015 Digit and tecla_proximo events SHALL be ignored in CALCULO.
REQ-016 Digit events SHALL be ignored in RESULTADO; tecla_proximo in RESULTADO SHALL act as tecla_limpar.
REQ-017 A tecla_limpar event in any state SHALL return the block to the reset state on the next cycle, aborting any CALCULO in progress.
REQ-018 Accumulation SHALL NOT overflow: W_PONT holds the worst case N_CAMPOS*(10^N_DIGITOS-1)*(2^W_PESO-1).

Reset
REQ-019 reset high SHALL immediately, without clock, force estado=ENTRADA, campo=0, digitos_bcd=0, n_digitos=0, pontuacao=0, resultado=0, pronto=0, all stored field values and accumulator to 0, and all edge-detect history to 1, so keys held through reset produce no event.
REQ-020 Reset asserted mid-entry or mid-CALCULO SHALL discard all partial data.

Verification
REQ-021 Assert reset during entry -> all outputs zero asynchronously; a key held across deassertion produces no event.
REQ-022 Press 1, 2, 3, 4 (one-cycle pulses) -> digitos_bcd=0x123, n_digitos=3, stored value 123; the 4 is ignored.
REQ-023 teclas=0b0000000110 rising together -> no change; digit 5 held for 6 cycles -> single digit entered.
REQ-024 Enter 10 in all 7 fields, pesos all 1, limiar=70 -> CALCULO lasts exactly 7 cycles, then pontuacao=70, resultado=1, pronto=1; repeat with limiar=71 -> resultado=0.
REQ-025 Fields 999, pesos 255, limiar 0 -> pontuacao=1783215 with no overflow; tecla_proximo in RESULTADO -> ENTRADA, campo=0.
REQ-026 tecla_limpar and digit 7 in the same cycle during CALCULO cycle 3 -> next cycle ENTRADA with all outputs zero and no digit stored.

Source files
------------

// File: rtl/detector_campos.sv
// Weighted-score detector: keypad entry of N_CAMPOS decimal fields, then a
// serial multiply-accumulate against per-field weights and a threshold compare.
module detector_campos #(
    parameter int N_CAMPOS  = 7,
    parameter int N_DIGITOS = 3,
    parameter int W_PESO    = 8,
    localparam int W_VAL    = $clog2(10**N_DIGITOS),
    localparam int W_CAMPO  = $clog2(N_CAMPOS),
    localparam int W_PONT   = W_VAL + W_PESO + W_CAMPO,
    localparam int W_ND     = $clog2(N_DIGITOS + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [9:0]                 teclas,
    input  logic                       tecla_proximo,
    input  logic                       tecla_limpar,
    input  logic [N_CAMPOS*W_PESO-1:0] pesos,
    input  logic [W_PONT-1:0]          limiar,
    output logic [1:0]                 estado,
    output logic [W_CAMPO-1:0]         campo,
    output logic [4*N_DIGITOS-1:0]     digitos_bcd,
    output logic [W_ND-1:0]            n_digitos,
    output logic [W_PONT-1:0]          pontuacao,
    output logic                       resultado,
    output logic                       pronto
);

    // state     | meaning
    // ENTRADA   | collecting digits of field `campo`
    // CALCULO   | one multiply-accumulate per cycle over all fields
    // RESULTADO | score and decision held until clear/next
    typedef enum logic [1:0] {
        ENTRADA   = 2'd0,
        CALCULO   = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    estado_t               estado_q, estado_n;
    logic [W_CAMPO-1:0]    campo_q, campo_n;
    logic [4*N_DIGITOS-1:0] bcd_q, bcd_n;
    logic [W_ND-1:0]       nd_q, nd_n;
    logic [W_VAL-1:0]      valor_q, valor_n;
    logic [W_VAL-1:0]      valores_q [N_CAMPOS];
    logic [W_VAL-1:0]      valores_n [N_CAMPOS];
    logic [W_PONT-1:0]     acc_q, acc_n;
    logic [W_CAMPO-1:0]    idx_q, idx_n;
    logic [W_PONT-1:0]     pont_q, pont_n;
    logic                  res_q, res_n;
    logic                  pronto_q, pronto_n;

    // Edge-detect history; reset to 1 so keys held through reset stay silent.
    logic [9:0]            teclas_h;
    logic                  prox_h, limpar_h;

    logic [9:0]            subida;
    logic                  ev_prox, ev_limpar, ev_digito, limpa;
    logic [3:0]            digito;
    logic [W_VAL+W_PESO-1:0] produto;
    logic [W_PONT-1:0]     soma;

    always_comb begin
        subida    = teclas & ~teclas_h;
        ev_prox   = tecla_proximo & ~prox_h;
        ev_limpar = tecla_limpar & ~limpar_h;
        ev_digito = $onehot(subida);
        digito    = 4'd0;
        for (int d = 0; d < 10; d++)
            if (subida[d]) digito = 4'(d);
        limpa = ev_limpar | (ev_prox && (estado_q == RESULTADO));
    end

    always_comb begin
        estado_n  = estado_q;
        campo_n   = campo_q;
        bcd_n     = bcd_q;
        nd_n      = nd_q;
        valor_n   = valor_q;
        valores_n = valores_q;
        acc_n     = acc_q;
        idx_n     = idx_q;
        pont_n    = pont_q;
        res_n     = res_q;
        pronto_n  = pronto_q;
        produto   = valores_q[idx_q] * pesos[idx_q*W_PESO +: W_PESO];
        soma      = acc_q + W_PONT'(produto);
        case (estado_q)
            ENTRADA: begin
                if (ev_prox) begin
                    valores_n[campo_q] = valor_q;
                    bcd_n   = '0;
                    nd_n    = '0;
                    valor_n = '0;
                    if (campo_q == W_CAMPO'(N_CAMPOS - 1)) begin
                        estado_n = CALCULO;
                        acc_n    = '0;
                        idx_n    = '0;
                    end else begin
                        campo_n = campo_q + 1'b1;
                    end
                end else if (ev_digito && (nd_q < W_ND'(N_DIGITOS))) begin
                    bcd_n   = {bcd_q[4*N_DIGITOS-5:0], digito};
                    valor_n = W_VAL'(valor_q * 10 + digito);
                    nd_n    = nd_q + 1'b1;
                end
            end
            CALCULO: begin
                acc_n = soma;
                if (idx_q == W_CAMPO'(N_CAMPOS - 1)) begin
                    estado_n = RESULTADO;
                    pont_n   = soma;
                    res_n    = (soma >= limiar);
                    pronto_n = 1'b1;
                end else begin
                    idx_n = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            teclas_h  <= '1;
            prox_h    <= 1'b1;
            limpar_h  <= 1'b1;
            estado_q  <= ENTRADA;
            campo_q   <= '0;
            bcd_q     <= '0;
            nd_q      <= '0;
            valor_q   <= '0;
            valores_q <= '{default: '0};
            acc_q     <= '0;
            idx_q     <= '0;
            pont_q    <= '0;
            res_q     <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            teclas_h <= teclas;
            prox_h   <= tecla_proximo;
            limpar_h <= tecla_limpar;
            if (limpa) begin
                estado_q  <= ENTRADA;
                campo_q   <= '0;
                bcd_q     <= '0;
                nd_q      <= '0;
                valor_q   <= '0;
                valores_q <= '{default: '0};
                acc_q     <= '0;
                idx_q     <= '0;
                pont_q    <= '0;
                res_q     <= 1'b0;
                pronto_q  <= 1'b0;
            end else begin
                estado_q  <= estado_n;
                campo_q   <= campo_n;
                bcd_q     <= bcd_n;
                nd_q      <= nd_n;
                valor_q   <= valor_n;
                valores_q <= valores_n;
                acc_q     <= acc_n;
                idx_q     <= idx_n;
                pont_q    <= pont_n;
                res_q     <= res_n;
                pronto_q  <= pronto_n;
            end
        end
    end

    assign estado      = estado_q;
    assign campo       = campo_q;
    assign digitos_bcd = bcd_q;
    assign n_digitos   = nd_q;
    assign pontuacao   = pont_q;
    assign resultado   = res_q;
    assign pronto      = pronto_q;

endmodule

// File: tb/tb_detector_campos.sv
// Directed + randomized bench for detector_campos, checked against a
// field-level behavioural model of keypad entry and weighted scoring.
module tb_detector_campos;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  teclas = '0;
    logic        tecla_proximo = 1'b0;
    logic        tecla_limpar = 1'b0;
    logic [55:0] pesos = '0;
    logic [20:0] limiar = '0;
    logic [1:0]  estado;
    logic [2:0]  campo;
    logic [11:0] digitos_bcd;
    logic [1:0]  n_digitos;
    logic [20:0] pontuacao;
    logic        resultado;
    logic        pronto;

    int vectors = 0;
    int miscompares = 0;

    // model state (plain integers, one value per field)
    int m_est, m_campo, m_val, m_nd, m_pont, m_res, m_pronto, m_left;
    int m_vals [7];
    logic [9:0] p_teclas;
    logic       p_prox, p_limp;

    detector_campos dut (
        .clock(clock), .reset(reset), .teclas(teclas),
        .tecla_proximo(tecla_proximo), .tecla_limpar(tecla_limpar),
        .pesos(pesos), .limiar(limiar), .estado(estado), .campo(campo),
        .digitos_bcd(digitos_bcd), .n_digitos(n_digitos),
        .pontuacao(pontuacao), .resultado(resultado), .pronto(pronto)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic int bcd_of(input int v);
        return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic model_clear();
        m_est = 0; m_campo = 0; m_val = 0; m_nd = 0;
        m_pont = 0; m_res = 0; m_pronto = 0; m_left = 0;
        for (int i = 0; i < 7; i++) m_vals[i] = 0;
    endtask

    task automatic model_reset();
        model_clear();
        p_teclas = '1; p_prox = 1'b1; p_limp = 1'b1;
    endtask

    task automatic model_step();
        logic [9:0] rise;
        logic ev_p, ev_l;
        int sum;
        rise = teclas & ~p_teclas;
        ev_p = tecla_proximo & ~p_prox;
        ev_l = tecla_limpar & ~p_limp;
        if (ev_l || (m_est == 2 && ev_p)) begin
            model_clear();
        end else if (m_est == 0) begin
            if (ev_p) begin
                m_vals[m_campo] = m_val;
                m_val = 0; m_nd = 0;
                if (m_campo == 6) begin m_est = 1; m_left = 7; end
                else m_campo++;
            end else if ($countones(rise) == 1 && m_nd < 3) begin
                for (int d = 0; d < 10; d++)
                    if (rise[d]) m_val = m_val * 10 + d;
                m_nd++;
            end
        end else if (m_est == 1) begin
            m_left--;
            if (m_left == 0) begin
                sum = 0;
                for (int i = 0; i < 7; i++) sum += m_vals[i] * int'(pesos[i*8 +: 8]);
                m_est = 2; m_pont = sum;
                m_res = (sum >= int'(limiar)) ? 1 : 0;
                m_pronto = 1;
            end
        end
        p_teclas = teclas; p_prox = tecla_proximo; p_limp = tecla_limpar;
    endtask

    task automatic compare_all();
        check("estado", 32'(estado), 32'(m_est));
        check("campo", 32'(campo), 32'(m_campo));
        check("digitos_bcd", 32'(digitos_bcd), 32'(bcd_of(m_val)));
        check("n_digitos", 32'(n_digitos), 32'(m_nd));
        check("pontuacao", 32'(pontuacao), 32'(m_pont));
        check("resultado", 32'(resultado), 32'(m_res));
        check("pronto", 32'(pronto), 32'(m_pronto));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all();
        #1 reset = 1'b0;
    endtask

    task automatic press(input int d);
        teclas = 10'(1 << d); tick();
        teclas = '0; tick();
    endtask

    task automatic next_key();
        tecla_proximo = 1'b1; tick();
        tecla_proximo = 1'b0; tick();
    endtask

    task automatic type_value(input int v);
        if (v >= 100) press(v / 100);
        if (v >= 10) press((v / 10) % 10);
        if (v > 0) press(v % 10);
    endtask

    // Enter all seven fields; the final next key is left for the caller.
    task automatic enter_fields(input int vals [7]);
        for (int i = 0; i < 7; i++) begin
            type_value(vals[i]);
            if (i < 6) next_key();
        end
    endtask

    task automatic run_calc(output int cycles);
        tecla_proximo = 1'b1; tick();
        tecla_proximo = 1'b0;
        cycles = 0;
        while (estado == 2'd1 && cycles < 20) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        int vals [7];
        int cyc;
        model_reset();

        // asynchronous reset mid-cycle, keys held across deassertion
        #2 reset = 1'b1;
        #1 compare_all();
        teclas = 10'b0000100000; tecla_limpar = 1'b1; tecla_proximo = 1'b1;
        #8 reset = 1'b0;
        repeat (3) tick();
        check("held_keys_no_digit", 32'(n_digitos), 32'd0);
        teclas = '0; tecla_limpar = 1'b0; tecla_proximo = 1'b0;
        tick();

        // 1,2,3 then 4 ignored
        press(1); press(2); press(3); press(4);
        check("bcd_123", 32'(digitos_bcd), 32'h123);
        check("nd_full", 32'(n_digitos), 32'd3);

        // reset during entry discards partial digits
        async_reset();
        tick();
        press(8);
        check("after_reset_entry", 32'(digitos_bcd), 32'h008);
        tecla_limpar = 1'b1; tick(); tecla_limpar = 1'b0; tick();

        // two digits rising together ignored; held digit counts once
        teclas = 10'b0000000110; tick();
        teclas = '0; tick();
        check("double_ignored", 32'(n_digitos), 32'd0);
        teclas = 10'b0000100000;
        repeat (6) tick();
        teclas = '0; tick();
        check("held_five", 32'(digitos_bcd), 32'h005);
        check("held_five_nd", 32'(n_digitos), 32'd1);
        tecla_limpar = 1'b1; tick(); tecla_limpar = 1'b0; tick();

        // all fields 10, weights 1, threshold 70 then 71
        for (int i = 0; i < 7; i++) vals[i] = 10;
        pesos = {7{8'd1}};
        limiar = 21'd70;
        enter_fields(vals);
        run_calc(cyc);
        check("calc_cycles", 32'(cyc), 32'd7);
        check("score_70", 32'(pontuacao), 32'd70);
        check("res_70", 32'(resultado), 32'd1);
        check("pronto_70", 32'(pronto), 32'd1);
        next_key();
        check("next_in_result", 32'(estado), 32'd0);
        limiar = 21'd71;
        enter_fields(vals);
        run_calc(cyc);
        check("res_71", 32'(resultado), 32'd0);
        tecla_limpar = 1'b1; tick(); tecla_limpar = 1'b0; tick();

        // worst case, no overflow
        for (int i = 0; i < 7; i++) vals[i] = 999;
        pesos = {7{8'd255}};
        limiar = '0;
        enter_fields(vals);
        run_calc(cyc);
        check("score_max", 32'(pontuacao), 32'd1783215);
        check("res_max", 32'(resultado), 32'd1);
        next_key();
        check("back_entrada", 32'(estado), 32'd0);
        check("back_campo", 32'(campo), 32'd0);

        // clear + digit 7 on the third CALCULO cycle
        for (int i = 0; i < 7; i++) vals[i] = i * 37;
        enter_fields(vals);
        tecla_proximo = 1'b1; tick(); tecla_proximo = 1'b0;
        tick(); tick();
        check("in_calc_c3", 32'(estado), 32'd1);
        tecla_limpar = 1'b1; teclas = 10'(1 << 7); tick();
        check("abort_estado", 32'(estado), 32'd0);
        check("abort_bcd", 32'(digitos_bcd), 32'd0);
        tecla_limpar = 1'b0; teclas = '0; tick();

        // reset mid-CALCULO
        enter_fields(vals);
        tecla_proximo = 1'b1; tick(); tecla_proximo = 1'b0; tick();
        async_reset();
        repeat (10) tick();

        // randomized full transactions
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 7; i++) vals[i] = $urandom_range(999);
            pesos = {$urandom, $urandom};
            limiar = 21'($urandom_range(1800000));
            enter_fields(vals);
            run_calc(cyc);
            check("rand_calc_cycles", 32'(cyc), 32'd7);
            next_key();
        end

        // randomized key chaos
        for (int t = 0; t < 600; t++) begin
            case ($urandom_range(7))
                0: teclas = 10'($urandom);
                1, 2: teclas = 10'(1 << $urandom_range(9));
                default: teclas = '0;
            endcase
            tecla_proximo = ($urandom_range(5) == 0);
            tecla_limpar  = ($urandom_range(60) == 0);
            if ($urandom_range(150) == 0) limiar = 21'($urandom_range(400000));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
